ex_stage: RTL and testbench

Execute stage of the 5-stage RV32I pipeline. It sits between the ID/EX register and the memory stage, and it consumes `o_forward_A`/`o_forward_B` from the forwarding unit to select operands. It computes the ALU result, branch decision and target, and detects load-use hazards for the decode stage. It also owns the EX/MEM pipeline register, whose `rd`/RegWrite outputs feed back into the forwarding unit.

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/alu.sv | 34 +++
 rtl/ex_stage.sv | 123 ++++++++++++
 tb/tb_ex_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I execute stage: ALU ops, forwarding selects,
// branch funct3 codes and the default datapath width.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    // 2'b11 is unused and falls back to the register-file operand.
    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_funct3_e;

endpackage

// File: rtl/alu.sv
// Purely combinational RV32I ALU; undefined op codes produce zero.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << shamt;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution, load-use hazard
// detection and the EX/MEM pipeline register.
module ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_valid_IDEX,
    input  logic [XLEN-1:0] i_pc_IDEX,
    input  logic [XLEN-1:0] i_rs1_data_IDEX,
    input  logic [XLEN-1:0] i_rs2_data_IDEX,
    input  logic [XLEN-1:0] i_imm_IDEX,
    input  logic [4:0]      i_rd_IDEX,
    input  logic [3:0]      i_alu_op_IDEX,
    input  logic            i_alu_src_IDEX,
    input  logic [2:0]      i_funct3_IDEX,
    input  logic            i_clu_RegWrite_IDEX,
    input  logic            i_clu_MemWrite_IDEX,
    input  logic            i_clu_MemRead_IDEX,
    input  logic            i_clu_Branch_IDEX,
    input  logic [1:0]      i_forward_A,
    input  logic [1:0]      i_forward_B,
    input  logic [XLEN-1:0] i_wb_data_MEMWB,
    input  logic [4:0]      i_rs1_IFID,
    input  logic [4:0]      i_rs2_IFID,
    output logic            o_valid_EXMEM,
    output logic [XLEN-1:0] o_alu_result_EXMEM,
    output logic [XLEN-1:0] o_store_data_EXMEM,
    output logic [4:0]      o_rd_EXMEM,
    output logic            o_clu_RegWrite_EXMEM,
    output logic            o_clu_MemWrite_EXMEM,
    output logic            o_clu_MemRead_EXMEM,
    output logic            o_branch_taken,
    output logic [XLEN-1:0] o_branch_target,
    output logic            o_hazard_stall
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic            cond;

    // The EXMEM path loops back from our own register in a single cycle.
    always_comb begin
        case (i_forward_A)
            FWD_EXMEM: op_a = o_alu_result_EXMEM;
            FWD_MEMWB: op_a = i_wb_data_MEMWB;
            default:   op_a = i_rs1_data_IDEX;
        endcase
        case (i_forward_B)
            FWD_EXMEM: op_b = o_alu_result_EXMEM;
            FWD_MEMWB: op_b = i_wb_data_MEMWB;
            default:   op_b = i_rs2_data_IDEX;
        endcase
    end

    assign alu_b = i_alu_src_IDEX ? i_imm_IDEX : op_b;

    alu #(.XLEN(XLEN)) u_alu (
        .op     (i_alu_op_IDEX),
        .a      (op_a),
        .b      (alu_b),
        .result (alu_result)
    );

    always_comb begin
        cond = 1'b0;
        case (i_funct3_IDEX)
            BR_EQ:   cond = (op_a == op_b);
            BR_NE:   cond = (op_a != op_b);
            BR_LT:   cond = ($signed(op_a) <  $signed(op_b));
            BR_GE:   cond = ($signed(op_a) >= $signed(op_b));
            BR_LTU:  cond = (op_a <  op_b);
            BR_GEU:  cond = (op_a >= op_b);
            default: cond = 1'b0;
        endcase
    end

    // Not gated by i_stall; the consumer qualifies it with its own stall.
    assign o_branch_taken  = i_valid_IDEX & i_clu_Branch_IDEX & cond;
    assign o_branch_target = i_pc_IDEX + i_imm_IDEX;

    assign o_hazard_stall = i_valid_IDEX & i_clu_MemRead_IDEX & (i_rd_IDEX != 5'd0)
                          & ((i_rd_IDEX == i_rs1_IFID) | (i_rd_IDEX == i_rs2_IFID));

    // o_valid_EXMEM marks a real instruction in MEM; i_stall freezes the
    // register (and beats i_flush), i_flush inserts a bubble.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid_EXMEM        <= 1'b0;
            o_alu_result_EXMEM   <= '0;
            o_store_data_EXMEM   <= '0;
            o_rd_EXMEM           <= 5'd0;
            o_clu_RegWrite_EXMEM <= 1'b0;
            o_clu_MemWrite_EXMEM <= 1'b0;
            o_clu_MemRead_EXMEM  <= 1'b0;
        end else if (i_stall) begin
            o_valid_EXMEM        <= o_valid_EXMEM;
        end else if (i_flush) begin
            o_valid_EXMEM        <= 1'b0;
            o_alu_result_EXMEM   <= '0;
            o_store_data_EXMEM   <= '0;
            o_rd_EXMEM           <= 5'd0;
            o_clu_RegWrite_EXMEM <= 1'b0;
            o_clu_MemWrite_EXMEM <= 1'b0;
            o_clu_MemRead_EXMEM  <= 1'b0;
        end else begin
            o_valid_EXMEM        <= i_valid_IDEX;
            o_alu_result_EXMEM   <= alu_result;
            o_store_data_EXMEM   <= op_b;
            o_rd_EXMEM           <= i_rd_IDEX;
            o_clu_RegWrite_EXMEM <= i_clu_RegWrite_IDEX & i_valid_IDEX;
            o_clu_MemWrite_EXMEM <= i_clu_MemWrite_IDEX & i_valid_IDEX;
            o_clu_MemRead_EXMEM  <= i_clu_MemRead_IDEX & i_valid_IDEX;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected EX/MEM contents are queued per edge
// and compared by a negedge monitor; combinational outputs are checked inline.
module tb_ex_stage;

    localparam int XLEN = 32;
    localparam int W    = 1 + XLEN + XLEN + 5 + 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall, flush, valid;
    logic [XLEN-1:0] pc, rs1_data, rs2_data, imm, wb_data;
    logic [4:0]      rd, rs1_ifid, rs2_ifid;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic [2:0]      funct3;
    logic            reg_write, mem_write, mem_read, branch;
    logic [1:0]      fwd_a, fwd_b;

    logic            valid_exmem;
    logic [XLEN-1:0] alu_result_exmem, store_data_exmem;
    logic [4:0]      rd_exmem;
    logic            rw_exmem, mw_exmem, mr_exmem;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            hazard_stall;

    logic [W-1:0] exp_q[$];
    int           n_vec = 0;
    int           n_bad = 0;

    ex_stage #(.XLEN(XLEN)) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_stall              (stall),
        .i_flush              (flush),
        .i_valid_IDEX         (valid),
        .i_pc_IDEX            (pc),
        .i_rs1_data_IDEX      (rs1_data),
        .i_rs2_data_IDEX      (rs2_data),
        .i_imm_IDEX           (imm),
        .i_rd_IDEX            (rd),
        .i_alu_op_IDEX        (alu_op),
        .i_alu_src_IDEX       (alu_src),
        .i_funct3_IDEX        (funct3),
        .i_clu_RegWrite_IDEX  (reg_write),
        .i_clu_MemWrite_IDEX  (mem_write),
        .i_clu_MemRead_IDEX   (mem_read),
        .i_clu_Branch_IDEX    (branch),
        .i_forward_A          (fwd_a),
        .i_forward_B          (fwd_b),
        .i_wb_data_MEMWB      (wb_data),
        .i_rs1_IFID           (rs1_ifid),
        .i_rs2_IFID           (rs2_ifid),
        .o_valid_EXMEM        (valid_exmem),
        .o_alu_result_EXMEM   (alu_result_exmem),
        .o_store_data_EXMEM   (store_data_exmem),
        .o_rd_EXMEM           (rd_exmem),
        .o_clu_RegWrite_EXMEM (rw_exmem),
        .o_clu_MemWrite_EXMEM (mw_exmem),
        .o_clu_MemRead_EXMEM  (mr_exmem),
        .o_branch_taken       (branch_taken),
        .o_branch_target      (branch_target),
        .o_hazard_stall       (hazard_stall)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] mk(input logic v, input logic [XLEN-1:0] res,
                                        input logic [XLEN-1:0] sd, input logic [4:0] r,
                                        input logic rw, input logic mw, input logic mr);
        return {v, res, sd, r, rw, mw, mr};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; valid = 0;
        pc = '0; rs1_data = '0; rs2_data = '0; imm = '0; wb_data = '0;
        rd = '0; rs1_ifid = '0; rs2_ifid = '0; alu_op = '0; alu_src = 0;
        funct3 = '0; reg_write = 0; mem_write = 0; mem_read = 0; branch = 0;
        fwd_a = '0; fwd_b = '0;
    endtask

    task automatic random_inputs();
        stall = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
        valid = 1'($urandom_range(0, 1));
        pc = $urandom; rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
        wb_data = $urandom; rd = 5'($urandom_range(0, 31));
        rs1_ifid = 5'($urandom_range(0, 31)); rs2_ifid = 5'($urandom_range(0, 31));
        alu_op = 4'($urandom_range(0, 15)); alu_src = 1'($urandom_range(0, 1));
        funct3 = 3'($urandom_range(0, 7));
        reg_write = 1'($urandom_range(0, 1)); mem_write = 1'($urandom_range(0, 1));
        mem_read = 1'($urandom_range(0, 1)); branch = 1'($urandom_range(0, 1));
        fwd_a = 2'($urandom_range(0, 3)); fwd_b = 2'($urandom_range(0, 3));
    endtask

    // Issue one rising edge with the current inputs and queue what EX/MEM must hold after it.
    task automatic edge_expect(input logic [W-1:0] e);
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic alu_vec(input logic [3:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [XLEN-1:0] res);
        idle_inputs();
        valid = 1; reg_write = 1; rd = 5'd10; alu_op = op;
        rs1_data = a; rs2_data = b;
        edge_expect(mk(1, res, b, 5'd10, 1, 0, 0));
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("exmem", {valid_exmem, alu_result_exmem, store_data_exmem, rd_exmem,
                                rw_exmem, mw_exmem, mr_exmem}, e);
            end
        end
    end

    // ---------------- driver ----------------
    initial begin
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        random_inputs();
        edge_expect('0);
        random_inputs();
        edge_expect('0);

        rst_n = 1;
        // ADD 8+8 into x3, store data rs2 = 3
        idle_inputs();
        valid = 1; reg_write = 1; rd = 5'd3; alu_op = 4'd0;
        rs1_data = 32'h8; imm = 32'h8; alu_src = 1; rs2_data = 32'h3;
        edge_expect(mk(1, 32'h10, 32'h3, 5'd3, 1, 0, 0));

        // A forwarded from EX/MEM (0x10) + 5
        rs1_data = 32'h99; imm = 32'h5; fwd_a = 2'b10; rd = 5'd4; rs2_data = 32'h7;
        edge_expect(mk(1, 32'h15, 32'h7, 5'd4, 1, 0, 0));

        // A forwarded from MEM/WB (0x20) + 5
        fwd_a = 2'b01; wb_data = 32'h20;
        edge_expect(mk(1, 32'h25, 32'h7, 5'd4, 1, 0, 0));

        // Store: fwd_a=11 acts as register, store data forwarded from EX/MEM (0x25)
        idle_inputs();
        valid = 1; mem_write = 1; rd = 5'd0; alu_op = 4'd0;
        rs1_data = 32'h100; imm = 32'h4; alu_src = 1; fwd_a = 2'b11;
        fwd_b = 2'b10; rs2_data = 32'hDEAD;
        edge_expect(mk(1, 32'h104, 32'h25, 5'd0, 0, 1, 0));

        // Invalid slot: controls masked, data captured (SUB 0-1)
        idle_inputs();
        valid = 0; reg_write = 1; mem_read = 1; mem_write = 1; rd = 5'd9;
        alu_op = 4'd1; rs1_data = 32'h0; rs2_data = 32'h1;
        edge_expect(mk(0, 32'hFFFF_FFFF, 32'h1, 5'd9, 0, 0, 0));

        // ALU corners
        idle_inputs();
        valid = 1; reg_write = 1; rd = 5'd6; alu_op = 4'd7;
        rs1_data = 32'h8000_0000; imm = 32'h24; alu_src = 1;
        edge_expect(mk(1, 32'hF800_0000, 32'h0, 5'd6, 1, 0, 0));
        alu_vec(4'd1,  32'h0,         32'h1,  32'hFFFF_FFFF);
        alu_vec(4'd12, 32'h5,         32'h6,  32'h0);
        alu_vec(4'd3,  32'hFFFF_FFFF, 32'h1,  32'h1);
        alu_vec(4'd4,  32'hFFFF_FFFF, 32'h1,  32'h0);
        alu_vec(4'd6,  32'h8000_0000, 32'h21, 32'h4000_0000);
        alu_vec(4'd2,  32'h1,         32'h1F, 32'h8000_0000);
        alu_vec(4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        alu_vec(4'd9,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        alu_vec(4'd8,  32'hF0F0_F0F0, 32'h0F00_0000, 32'hFFF0_F0F0);

        // Branch decisions and target (combinational)
        idle_inputs();
        valid = 1; branch = 1; alu_op = 4'd0;
        rs1_data = 32'hFFFF_FFFF; rs2_data = 32'h1;
        pc = 32'hFFFF_FFF0; imm = 32'h20;
        funct3 = 3'b100; #1 check("br_lt",   W'(branch_taken), W'(1'b1));
        funct3 = 3'b110; #1 check("br_ltu",  W'(branch_taken), W'(1'b0));
        funct3 = 3'b111; #1 check("br_geu",  W'(branch_taken), W'(1'b1));
        funct3 = 3'b010; #1 check("br_f010", W'(branch_taken), W'(1'b0));
        funct3 = 3'b001; #1 check("br_ne",   W'(branch_taken), W'(1'b1));
        fwd_b = 2'b01; wb_data = 32'hFFFF_FFFF; funct3 = 3'b000;
        #1 check("br_eq_fwd", W'(branch_taken), W'(1'b1));
        valid = 0;
        #1 check("br_invalid", W'(branch_taken), W'(1'b0));
        #1 check("br_target", W'(branch_target), W'(32'h10));
        valid = 1; fwd_b = 2'b00;
        edge_expect(mk(1, 32'h0, 32'h1, 5'd0, 0, 0, 0));

        // Load-use hazard
        idle_inputs();
        valid = 1; mem_read = 1; reg_write = 1; rd = 5'd5; rs2_ifid = 5'd5; rs1_ifid = 5'd2;
        #1 check("hazard_rs2", W'(hazard_stall), W'(1'b1));
        rd = 5'd0; rs2_ifid = 5'd0;
        #1 check("hazard_x0", W'(hazard_stall), W'(1'b0));
        rd = 5'd2; rs2_ifid = 5'd7;
        #1 check("hazard_rs1", W'(hazard_stall), W'(1'b1));
        mem_read = 0;
        #1 check("hazard_noload", W'(hazard_stall), W'(1'b0));
        mem_read = 1; rd = 5'd5; alu_op = 4'd0; rs1_data = 32'h40; alu_src = 1;
        edge_expect(mk(1, 32'h40, 32'h0, 5'd5, 1, 0, 1));

        // Stall beats flush, then flush bubbles once the stall drops
        idle_inputs();
        valid = 1; reg_write = 1; rd = 5'd7; alu_op = 4'd10; alu_src = 1;
        imm = 32'h1234; rs2_data = 32'hAA;
        edge_expect(mk(1, 32'h1234, 32'hAA, 5'd7, 1, 0, 0));
        stall = 1; flush = 1; imm = 32'h5555; rd = 5'd8;
        for (int i = 0; i < 3; i++) edge_expect(mk(1, 32'h1234, 32'hAA, 5'd7, 1, 0, 0));
        stall = 0;
        edge_expect('0);

        // Reset wins over an active stall
        flush = 0; imm = 32'h77;
        edge_expect(mk(1, 32'h77, 32'hAA, 5'd8, 1, 0, 0));
        stall = 1; rst_n = 0;
        edge_expect('0);
        rst_n = 1; stall = 0;

        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
